uncached_unit: RTL and testbench
================================

// Module: uncached_unit
// PURPOSE
//  Responder for one MMU->dcache port (dcacheN_* req/addr_ok/data_ok protocol) serving uncached accesses (MAT=0).
//  Queues accepted requests in order; issues each as a single-beat read or write on the memory side (AXI bridge).
//  Returns data_ok/rdata in acceptance order; one memory transaction outstanding at a time.
// PARAMETERS
//  QDEPTH  2  request queue entries (power of 2, >=1); addr_ok deasserts when all QDEPTH entries are in use
// PORTS
//  clk        in   1   core clock
//  reset      in   1   synchronous, active-high
//  req        in   1   request valid (from mmu dcacheN_req gated by dcacheN_uncached)
//  wr         in   1   1=store, 0=load
//  size       in   2   0=byte 1=half 2=word
//  wstrb      in   4   byte enables for store
//  addr       in   32  physical address
//  wdata      in   32  store data
//  addr_ok    out  1   request accepted this cycle when req&addr_ok
//  data_ok    out  1   one-cycle pulse: oldest accepted request completed
//  rdata      out  32  load data, valid with data_ok (undefined for stores)
//  rd_req     out  1   memory read request
//  rd_type    out  3   {1'b0,size}
//  rd_addr    out  32  read address
//  rd_rdy     in   1   read request accepted when rd_req&rd_rdy
//  ret_valid  in   1   read data beat valid
//  ret_last   in   1   last beat (always 1 for uncached; ignored except as check)
//  ret_data   in   32  read data
//  wr_req     out  1   memory write request
//  wr_type    out  3   {1'b0,size}
//  wr_addr    out  32  write address
//  wr_wstrb   out  4   write strobes
//  wr_data    out  32  write data
//  wr_rdy     in   1   write accepted when wr_req&wr_rdy
//  wr_bvalid  in   1   write response (completion)
// BEHAVIOUR
//  Reset: queue empty, FSM IDLE, addr_ok=1 from first cycle after reset, data_ok/rd_req/wr_req=0, rdata=0.
//  Accept: req&addr_ok in cycle N pushes {wr,size,wstrb,addr,wdata}; addr_ok = !full (registered count).
//  Full: no push even if a pop occurs in the same cycle; simultaneous push+pop when not full keeps count.
//  FSM: IDLE -> RD_REQ (head is load) | WR_REQ (head is store); earliest rd_req/wr_req at N+1.
//   RD_REQ: rd_req=1 until rd_rdy -> RD_WAIT.  RD_WAIT: on ret_valid latch ret_data -> RESP.
//   WR_REQ: wr_req=1 until wr_rdy -> WR_WAIT.  WR_WAIT: on wr_bvalid -> RESP.
//   RESP: data_ok=1 one cycle, rdata=latched data, pop head -> IDLE (or directly RD_REQ/WR_REQ if queue non-empty).
//  Request outputs held stable from assertion until handshake; taken from queue head, not from live inputs.
//  Min load latency: accept N, rd_req N+1, rd_rdy N+1, ret_valid N+2, data_ok N+3.
//  Strict program order: a load behind a store waits for that store's wr_bvalid.
//  ret_valid/wr_bvalid outside RD_WAIT/WR_WAIT ignored; ret_last=0 in RD_WAIT is protocol error (sim assert).
//  Reset mid-operation: queue flushed, FSM IDLE, in-flight memory transaction dropped (bridge reset alongside).
// CONFIGURATION
//  UNCACHED_WRITE_POST_EN defined: store completes on wr_req&wr_rdy; WR_WAIT skipped, wr_bvalid ignored,
//   data_ok for store at handshake+1; a following load still waits for wr_bvalid count of posted stores = 0
//   (internal outstanding-write counter, width clog2(QDEPTH+1)).
//  Undefined: store data_ok only after wr_bvalid, as above; no counter.
// TESTING
//  Load word 0x1FE0_0000, rd_rdy=1, ret_data=0xDEADBEEF next cycle -> rd_type=3'b010, data_ok at N+3, rdata=0xDEADBEEF.
//  Store byte addr 0x1FE0_0003 wstrb=4'b1000 wdata=0xAA00_0000 -> wr_type=3'b000, wr_wstrb=4'b1000; data_ok 1 cycle after wr_bvalid.
//  QDEPTH=2, rd_rdy=0, three back-to-back reqs -> addr_ok=0 on third; accepted after first data_ok.
//  Store then load, wr_bvalid delayed 5 cycles -> rd_req not asserted before wr_bvalid; data_ok order store, load.
//  reset asserted in RD_WAIT with 2 queued -> next cycle addr_ok=1, data_ok=0, rd_req=0; late ret_valid ignored.
//  UNCACHED_WRITE_POST_EN: store wr_rdy at cycle M, wr_bvalid at M+6 -> store data_ok at M+1; following load rd_req >= M+6.

Source files
------------

// File: rtl/uncached_unit.sv
// Uncached load/store responder: in-order request queue, one single-beat memory transaction at a time.
// Define UNCACHED_WRITE_POST_EN to complete stores at the write handshake instead of at wr_bvalid.
module uncached_unit #(
  parameter int unsigned QDEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  output logic        rd_req,
  output logic [2:0]  rd_type,
  output logic [31:0] rd_addr,
  input  logic        rd_rdy,
  input  logic        ret_valid,
  input  logic        ret_last,
  input  logic [31:0] ret_data,
  output logic        wr_req,
  output logic [2:0]  wr_type,
  output logic [31:0] wr_addr,
  output logic [3:0]  wr_wstrb,
  output logic [31:0] wr_data,
  input  logic        wr_rdy,
  input  logic        wr_bvalid
);

  localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CW = $clog2(QDEPTH + 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD_REQ  = 3'd1;
  localparam logic [2:0] RD_WAIT = 3'd2;
  localparam logic [2:0] WR_REQ  = 3'd3;
  localparam logic [2:0] WR_WAIT = 3'd4;
  localparam logic [2:0] RESP    = 3'd5;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } entry_t;

  entry_t          q_mem [QDEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic [2:0]      state_q, state_d;
  logic [31:0]     rdata_q;
  entry_t          head;
  logic            push, pop, next_wr;
  logic            rd_gate, wr_gate;
  logic [2:0]      wr_done_state;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(QDEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  assign head    = q_mem[rd_ptr_q];
  assign addr_ok = (count_q != CW'(QDEPTH));
  assign push    = req & addr_ok;
  assign pop     = (state_q == RESP);
  // Head after this cycle's pop: the next queued entry, else an entry being pushed right now.
  assign next_wr = (count_q > CW'(1)) ? q_mem[ptr_inc(rd_ptr_q)].wr : wr;

`ifdef UNCACHED_WRITE_POST_EN
  logic [CW-1:0] wcnt_q;
  logic          wr_hs, wr_ret;

  assign wr_hs  = wr_req & wr_rdy;
  assign wr_ret = wr_bvalid & (wcnt_q != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      wcnt_q <= '0;
    end else begin
      unique case ({wr_hs, wr_ret})
        2'b10:   wcnt_q <= wcnt_q + 1'b1;
        2'b01:   wcnt_q <= wcnt_q - 1'b1;
        default: wcnt_q <= wcnt_q;
      endcase
    end
  end

  // Loads must not overtake posted stores still awaiting their write response.
  assign rd_gate       = (wcnt_q == '0);
  assign wr_gate       = (wcnt_q != '1);
  assign wr_done_state = RESP;
`else
  assign rd_gate       = 1'b1;
  assign wr_gate       = 1'b1;
  assign wr_done_state = WR_WAIT;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (count_q != '0)  state_d = head.wr ? WR_REQ : RD_REQ;
        else if (push)      state_d = wr ? WR_REQ : RD_REQ;
      end
      RD_REQ:  if (rd_req && rd_rdy) state_d = RD_WAIT;
      RD_WAIT: if (ret_valid)        state_d = RESP;
      WR_REQ:  if (wr_req && wr_rdy) state_d = wr_done_state;
      WR_WAIT: if (wr_bvalid)        state_d = RESP;
      RESP: begin
        if ((count_q > CW'(1)) || push) state_d = next_wr ? WR_REQ : RD_REQ;
        else                            state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (state_q == RD_WAIT && ret_valid) rdata_q <= ret_data;
    end
  end

  always_ff @(posedge clk) begin
    if (push) q_mem[wr_ptr_q] <= '{wr: wr, size: size, wstrb: wstrb, addr: addr, wdata: wdata};
  end

  assign data_ok  = (state_q == RESP);
  assign rdata    = rdata_q;
  assign rd_req   = (state_q == RD_REQ) & rd_gate;
  assign rd_type  = {1'b0, head.size};
  assign rd_addr  = head.addr;
  assign wr_req   = (state_q == WR_REQ) & wr_gate;
  assign wr_type  = {1'b0, head.size};
  assign wr_addr  = head.addr;
  assign wr_wstrb = head.wstrb;
  assign wr_data  = head.wdata;

  ret_last_chk: assert property (@(posedge clk) disable iff (reset)
    (state_q == RD_WAIT && ret_valid) |-> ret_last);

endmodule

// File: tb/tb_uncached_unit.sv
// Directed bench for uncached_unit: per-cycle vector table plus queue-full, ordering and reset sequences.
module tb_uncached_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr, wdata;
  logic        addr_ok, data_ok;
  logic [31:0] rdata;
  logic        rd_req;
  logic [2:0]  rd_type;
  logic [31:0] rd_addr;
  logic        rd_rdy, ret_valid, ret_last;
  logic [31:0] ret_data;
  logic        wr_req;
  logic [2:0]  wr_type;
  logic [31:0] wr_addr;
  logic [3:0]  wr_wstrb;
  logic [31:0] wr_data;
  logic        wr_rdy, wr_bvalid;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uncached_unit #(.QDEPTH(2)) dut (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size), .wstrb(wstrb), .addr(addr),
    .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata), .rd_req(rd_req),
    .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy), .ret_valid(ret_valid),
    .ret_last(ret_last), .ret_data(ret_data), .wr_req(wr_req), .wr_type(wr_type),
    .wr_addr(wr_addr), .wr_wstrb(wr_wstrb), .wr_data(wr_data), .wr_rdy(wr_rdy),
    .wr_bvalid(wr_bvalid)
  );

  typedef struct {
    logic        req, wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr, wdata;
    logic        rd_rdy, ret_valid;
    logic [31:0] ret_data;
    logic        wr_rdy, wr_bvalid;
    logic        e_addr_ok, e_data_ok, e_rd_req, e_wr_req, chk_rdata;
    logic [31:0] e_rdata;
    logic [2:0]  e_type;
    logic [31:0] e_maddr;
    logic [3:0]  e_wstrb;
    logic [31:0] e_wdata;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic idle_inputs();
    req = 1'b0; wr = 1'b0; size = 2'd0; wstrb = 4'h0; addr = 32'h0; wdata = 32'h0;
    rd_rdy = 1'b0; ret_valid = 1'b0; ret_data = 32'h0; wr_rdy = 1'b0; wr_bvalid = 1'b0;
  endtask

  // Inputs for a cycle are driven just after posedge; outputs are sampled at negedge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic push_req(input logic w, input logic [1:0] s, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] st);
    req = 1'b1; wr = w; size = s; addr = a; wdata = d; wstrb = st;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // req wr size wstrb addr wdata | rd_rdy ret_v ret_data wr_rdy bvalid |
    // e_ok e_dok e_rd e_wr chk_rd e_rdata e_type e_maddr e_wstrb e_wdata
    vecs[0]  = '{1'b1, 1'b0, 2'd2, 4'h0, 32'h1FE0_0000, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0,
                 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 3'b000, 32'h0, 4'h0, 32'h0};
    vecs[1]  = '{1'b0, 1'b0, 2'd0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0,
                 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 3'b010, 32'h1FE0_0000, 4'h0, 32'h0};
    vecs[2]  = '{1'b0, 1'b0, 2'd0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0,
                 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 3'b000, 32'h0, 4'h0, 32'h0};
    vecs[3]  = '{1'b0, 1'b0, 2'd0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0,
                 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 3'b000, 32'h0, 4'h0, 32'h0};
    vecs[4]  = '{1'b0, 1'b0, 2'd0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0,
                 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 3'b000, 32'h0, 4'h0, 32'h0};
    vecs[5]  = '{1'b1, 1'b1, 2'd0, 4'b1000, 32'h1FE0_0003, 32'hAA00_0000, 1'b0, 1'b0, 32'h0,
                 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 3'b000, 32'h0, 4'h0, 32'h0};
    vecs[6]  = '{1'b0, 1'b0, 2'd2, 4'h0, 32'h0000_5555, 32'h0000_1234, 1'b0, 1'b0, 32'h0,
                 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 3'b000, 32'h1FE0_0003,
                 4'b1000, 32'hAA00_0000};
    vecs[7]  = '{1'b0, 1'b0, 2'd0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0,
                 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 3'b000, 32'h1FE0_0003, 4'b1000,
                 32'hAA00_0000};
    vecs[8]  = '{1'b0, 1'b0, 2'd0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0,
                 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 3'b000, 32'h0, 4'h0, 32'h0};
    vecs[9]  = '{1'b0, 1'b0, 2'd0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1,
                 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 3'b000, 32'h0, 4'h0, 32'h0};
    vecs[10] = '{1'b0, 1'b0, 2'd0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0,
                 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 3'b000, 32'h0, 4'h0, 32'h0};
    vecs[11] = '{1'b0, 1'b0, 2'd0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h1234_5678, 1'b0, 1'b1,
                 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 3'b000, 32'h0, 4'h0, 32'h0};
    vecs[12] = '{1'b0, 1'b0, 2'd0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0,
                 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 3'b000, 32'h0, 4'h0, 32'h0};

    ret_last = 1'b1;
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    chk("reset addr_ok", 32'(addr_ok), 32'd1);
    chk("reset data_ok", 32'(data_ok), 32'd0);
    chk("reset rd_req", 32'(rd_req), 32'd0);
    chk("reset wr_req", 32'(wr_req), 32'd0);
    chk("reset rdata", rdata, 32'h0);
    next_cycle();

    // Load word then store byte, one vector per cycle.
    for (int i = 0; i < 13; i++) begin
      req = vecs[i].req; wr = vecs[i].wr; size = vecs[i].size; wstrb = vecs[i].wstrb;
      addr = vecs[i].addr; wdata = vecs[i].wdata; rd_rdy = vecs[i].rd_rdy;
      ret_valid = vecs[i].ret_valid; ret_data = vecs[i].ret_data;
      wr_rdy = vecs[i].wr_rdy; wr_bvalid = vecs[i].wr_bvalid;
      @(negedge clk);
      chk($sformatf("vec%0d addr_ok", i), 32'(addr_ok), 32'(vecs[i].e_addr_ok));
      chk($sformatf("vec%0d data_ok", i), 32'(data_ok), 32'(vecs[i].e_data_ok));
      chk($sformatf("vec%0d rd_req", i), 32'(rd_req), 32'(vecs[i].e_rd_req));
      chk($sformatf("vec%0d wr_req", i), 32'(wr_req), 32'(vecs[i].e_wr_req));
      if (vecs[i].chk_rdata) chk($sformatf("vec%0d rdata", i), rdata, vecs[i].e_rdata);
      if (vecs[i].e_rd_req) begin
        chk($sformatf("vec%0d rd_type", i), 32'(rd_type), 32'(vecs[i].e_type));
        chk($sformatf("vec%0d rd_addr", i), rd_addr, vecs[i].e_maddr);
      end
      if (vecs[i].e_wr_req) begin
        chk($sformatf("vec%0d wr_type", i), 32'(wr_type), 32'(vecs[i].e_type));
        chk($sformatf("vec%0d wr_addr", i), wr_addr, vecs[i].e_maddr);
        chk($sformatf("vec%0d wr_wstrb", i), 32'(wr_wstrb), 32'(vecs[i].e_wstrb));
        chk($sformatf("vec%0d wr_data", i), wr_data, vecs[i].e_wdata);
      end
      next_cycle();
    end

    // Queue full: three back-to-back loads with rd_rdy low.
    push_req(1'b0, 2'd2, 32'h1FE0_0010, 32'h0, 4'h0);
    @(negedge clk); chk("full f0 addr_ok", 32'(addr_ok), 32'd1);
    next_cycle();
    push_req(1'b0, 2'd2, 32'h1FE0_0014, 32'h0, 4'h0);
    @(negedge clk); chk("full f1 addr_ok", 32'(addr_ok), 32'd1);
    next_cycle();
    push_req(1'b0, 2'd2, 32'h1FE0_0018, 32'h0, 4'h0);
    @(negedge clk);
    chk("full f2 addr_ok", 32'(addr_ok), 32'd0);
    chk("full f2 rd_addr", rd_addr, 32'h1FE0_0010);
    next_cycle();
    push_req(1'b0, 2'd2, 32'h1FE0_0018, 32'h0, 4'h0); rd_rdy = 1'b1;
    @(negedge clk);
    chk("full f3 addr_ok", 32'(addr_ok), 32'd0);
    chk("full f3 rd_req", 32'(rd_req), 32'd1);
    next_cycle();
    push_req(1'b0, 2'd2, 32'h1FE0_0018, 32'h0, 4'h0); ret_valid = 1'b1; ret_data = 32'h1111_1111;
    @(negedge clk); chk("full f4 addr_ok", 32'(addr_ok), 32'd0);
    next_cycle();
    push_req(1'b0, 2'd2, 32'h1FE0_0018, 32'h0, 4'h0);
    @(negedge clk);
    chk("full f5 data_ok", 32'(data_ok), 32'd1);
    chk("full f5 rdata", rdata, 32'h1111_1111);
    chk("full f5 addr_ok", 32'(addr_ok), 32'd0);
    next_cycle();
    push_req(1'b0, 2'd2, 32'h1FE0_0018, 32'h0, 4'h0); rd_rdy = 1'b1;
    @(negedge clk);
    chk("full f6 addr_ok", 32'(addr_ok), 32'd1);
    chk("full f6 rd_req", 32'(rd_req), 32'd1);
    chk("full f6 rd_addr", rd_addr, 32'h1FE0_0014);
    next_cycle();
    ret_valid = 1'b1; ret_data = 32'h2222_2222;
    @(negedge clk); chk("full f7 data_ok", 32'(data_ok), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("full f8 data_ok", 32'(data_ok), 32'd1);
    chk("full f8 rdata", rdata, 32'h2222_2222);
    next_cycle();
    rd_rdy = 1'b1;
    @(negedge clk);
    chk("full f9 rd_req", 32'(rd_req), 32'd1);
    chk("full f9 rd_addr", rd_addr, 32'h1FE0_0018);
    next_cycle();
    ret_valid = 1'b1; ret_data = 32'h3333_3333;
    next_cycle();
    @(negedge clk);
    chk("full f11 data_ok", 32'(data_ok), 32'd1);
    chk("full f11 rdata", rdata, 32'h3333_3333);
    next_cycle();

    // Store followed by load: the load may not issue before the store retires.
    push_req(1'b1, 2'd2, 32'h1FE0_0020, 32'hCAFE_F00D, 4'hF);
    next_cycle();
    push_req(1'b0, 2'd2, 32'h1FE0_0024, 32'h0, 4'h0); wr_rdy = 1'b1;
    @(negedge clk);
    chk("order s1 wr_req", 32'(wr_req), 32'd1);
    chk("order s1 wr_addr", wr_addr, 32'h1FE0_0020);
    next_cycle();
`ifndef UNCACHED_WRITE_POST_EN
    for (int c = 2; c <= 7; c++) begin
      if (c == 7) wr_bvalid = 1'b1;
      @(negedge clk);
      chk($sformatf("order s%0d rd_req", c), 32'(rd_req), 32'd0);
      chk($sformatf("order s%0d data_ok", c), 32'(data_ok), 32'd0);
      next_cycle();
    end
    @(negedge clk);
    chk("order s8 data_ok", 32'(data_ok), 32'd1);
    chk("order s8 rd_req", 32'(rd_req), 32'd0);
    next_cycle();
`else
    @(negedge clk);
    chk("post s2 data_ok", 32'(data_ok), 32'd1);
    next_cycle();
    for (int c = 3; c <= 7; c++) begin
      if (c == 7) wr_bvalid = 1'b1;
      @(negedge clk);
      chk($sformatf("post s%0d rd_req", c), 32'(rd_req), 32'd0);
      chk($sformatf("post s%0d data_ok", c), 32'(data_ok), 32'd0);
      next_cycle();
    end
`endif
    rd_rdy = 1'b1;
    @(negedge clk);
    chk("order load rd_req", 32'(rd_req), 32'd1);
    chk("order load rd_addr", rd_addr, 32'h1FE0_0024);
    next_cycle();
    ret_valid = 1'b1; ret_data = 32'h4444_4444;
    @(negedge clk); chk("order ret data_ok", 32'(data_ok), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("order load data_ok", 32'(data_ok), 32'd1);
    chk("order load rdata", rdata, 32'h4444_4444);
    next_cycle();

    // Reset while waiting for read data with two loads queued.
    push_req(1'b0, 2'd2, 32'h1FE0_0030, 32'h0, 4'h0);
    next_cycle();
    push_req(1'b0, 2'd2, 32'h1FE0_0034, 32'h0, 4'h0); rd_rdy = 1'b1;
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0; ret_valid = 1'b1; ret_data = 32'h5555_5555;
    @(negedge clk);
    chk("rst r3 addr_ok", 32'(addr_ok), 32'd1);
    chk("rst r3 data_ok", 32'(data_ok), 32'd0);
    chk("rst r3 rd_req", 32'(rd_req), 32'd0);
    chk("rst r3 wr_req", 32'(wr_req), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("rst r4 data_ok", 32'(data_ok), 32'd0);
    chk("rst r4 rd_req", 32'(rd_req), 32'd0);
    chk("rst r4 rdata", rdata, 32'h0);
    next_cycle();
    @(negedge clk);
    chk("rst r5 data_ok", 32'(data_ok), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
